// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one grant per cycle among int/mult/div/ld-st units, registered broadcast.
// Define CDB_FIXED_PRIO_EN for fixed priority 0>1>2>3; otherwise round-robin.
module cdb_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            req_i,
    input  logic [4*TAG_W-1:0]    req_tag_i,
    input  logic [4*DATA_W-1:0]   req_data_i,
    input  logic                  flush_i,
    output logic [3:0]            gnt_o,
    output logic                  cdb_valid_o,
    output logic [TAG_W-1:0]      cdb_tag_o,
    output logic [DATA_W-1:0]     cdb_data_o,
    output logic [1:0]            cdb_src_o
);

    logic [1:0]        ptr_q;
    logic [1:0]        ptr_d;
    logic [3:0]        gnt_s;
    logic [1:0]        gnt_idx_s;
    logic              xfer_s;
    logic [TAG_W-1:0]  tag_sel_s;
    logic [DATA_W-1:0] data_sel_s;
    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [1:0]        cdb_src_q;

    // Grant selection: first requester found scanning upward from ptr_q (ptr_q stays 0 in fixed mode)
    always_comb begin
        logic       found_s;
        logic [1:0] cand_s;
        found_s   = 1'b0;
        cand_s    = 2'd0;
        gnt_idx_s = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand_s = ptr_q + 2'(k);
            if (!found_s && req_i[cand_s]) begin
                found_s   = 1'b1;
                gnt_idx_s = cand_s;
            end else begin
                found_s   = found_s;
            end
        end
        if (!reset || flush_i || !found_s) begin
            gnt_s = 4'b0000;
        end else begin
            gnt_s = 4'b0001 << gnt_idx_s;
        end
    end

    assign xfer_s = |(req_i & gnt_s);

    // Result mux for the granted unit
    always_comb begin
        tag_sel_s  = {TAG_W{1'b0}};
        data_sel_s = {DATA_W{1'b0}};
        for (int n = 0; n < 4; n++) begin
            if (gnt_s[n]) begin
                tag_sel_s  = req_tag_i[n*TAG_W +: TAG_W];
                data_sel_s = req_data_i[n*DATA_W +: DATA_W];
            end else begin
                tag_sel_s  = tag_sel_s;
                data_sel_s = data_sel_s;
            end
        end
    end

    // Next pointer: flush returns to unit 0, a transfer moves past the winner
    always_comb begin
`ifdef CDB_FIXED_PRIO_EN
        ptr_d = 2'd0;
`else
        if (flush_i) begin
            ptr_d = 2'd0;
        end else if (xfer_s) begin
            ptr_d = gnt_idx_s + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
`endif
    end

    // Pointer and broadcast registers; payload holds when nothing is transferred
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q       <= 2'd0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= {TAG_W{1'b0}};
            cdb_data_q  <= {DATA_W{1'b0}};
            cdb_src_q   <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= xfer_s;
            if (xfer_s) begin
                cdb_tag_q  <= tag_sel_s;
                cdb_data_q <= data_sel_s;
                cdb_src_q  <= gnt_idx_s;
            end else begin
                cdb_tag_q  <= cdb_tag_q;
                cdb_data_q <= cdb_data_q;
                cdb_src_q  <= cdb_src_q;
            end
        end
    end

    assign gnt_o       = gnt_s;
    assign cdb_valid_o = cdb_valid_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_data_o  = cdb_data_q;
    assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus reset corner sequences.
module tb_cdb_arbiter;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [3:0]          req_i = 4'b0000;
    logic [4*TAG_W-1:0]  req_tag_i;
    logic [4*DATA_W-1:0] req_data_i;
    logic                flush_i = 1'b0;
    logic [3:0]          gnt_o;
    logic                cdb_valid_o;
    logic [TAG_W-1:0]    cdb_tag_o;
    logic [DATA_W-1:0]   cdb_data_o;
    logic [1:0]          cdb_src_o;

    int total = 0;
    int bad   = 0;

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .req_i(req_i), .req_tag_i(req_tag_i),
        .req_data_i(req_data_i), .flush_i(flush_i), .gnt_o(gnt_o),
        .cdb_valid_o(cdb_valid_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o),
        .cdb_src_o(cdb_src_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       flush;
        logic [3:0] req;
        logic [3:0] gnt_rr;
        logic [3:0] gnt_fx;
    } vec_t;

    vec_t              vecs[14];
    logic [TAG_W-1:0]  utag[4];
    logic [DATA_W-1:0] udata[4];

    logic              exp_valid;
    logic [TAG_W-1:0]  exp_tag;
    logic [DATA_W-1:0] exp_data;
    logic [1:0]        exp_src;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_outs(input string tag_s);
        chk({tag_s, "_valid"}, 64'(cdb_valid_o), 64'(exp_valid));
        chk({tag_s, "_tag"},   64'(cdb_tag_o),   64'(exp_tag));
        chk({tag_s, "_data"},  64'(cdb_data_o),  64'(exp_data));
        chk({tag_s, "_src"},   64'(cdb_src_o),   64'(exp_src));
    endtask

    // Reference broadcast model driven by the hand-written expected grant
    task automatic model_edge(input logic [3:0] eg);
        exp_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (eg[n]) begin
                exp_valid = 1'b1;
                exp_tag   = utag[n];
                exp_data  = udata[n];
                exp_src   = 2'(n);
            end
        end
    endtask

    initial begin
        logic [3:0] eg;
        utag[0] = 5'd3;  utag[1] = 5'd17; utag[2] = 5'd9;  utag[3] = 5'd30;
        udata[0] = 32'h1111_0000; udata[1] = 32'h2222_0001;
        udata[2] = 32'hDEAD_BEEF; udata[3] = 32'h4444_0003;
        for (int n = 0; n < 4; n++) begin
            req_tag_i[n*TAG_W +: TAG_W]    = utag[n];
            req_data_i[n*DATA_W +: DATA_W] = udata[n];
        end

        //          flush  req      rr-grant fixed-grant
        vecs[0]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001};
        vecs[1]  = '{1'b0, 4'b1111, 4'b0010, 4'b0001};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0100, 4'b0001};
        vecs[3]  = '{1'b0, 4'b1111, 4'b1000, 4'b0001};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000};
        vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100};
        vecs[7]  = '{1'b0, 4'b1001, 4'b1000, 4'b0001};
        vecs[8]  = '{1'b0, 4'b1001, 4'b0001, 4'b0001};
        vecs[9]  = '{1'b1, 4'b0010, 4'b0000, 4'b0000};
        vecs[10] = '{1'b0, 4'b0011, 4'b0001, 4'b0001};
        vecs[11] = '{1'b0, 4'b1010, 4'b0010, 4'b0010};
        vecs[12] = '{1'b0, 4'b1010, 4'b1000, 4'b0010};
        vecs[13] = '{1'b0, 4'b1010, 4'b0010, 4'b0010};

        exp_valid = 1'b0; exp_tag = '0; exp_data = '0; exp_src = 2'd0;

        // Reset held with all units requesting
        req_i = 4'b1111;
        #12;
        chk("rst_gnt", 64'(gnt_o), 64'(4'b0000));
        chk_outs("rst");
        @(negedge clock);
        req_i = 4'b0000;
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            flush_i = vecs[i].flush;
            req_i   = vecs[i].req;
`ifdef CDB_FIXED_PRIO_EN
            eg = vecs[i].gnt_fx;
`else
            eg = vecs[i].gnt_rr;
`endif
            #1;
            chk($sformatf("v%0d_gnt", i), 64'(gnt_o), 64'(eg));
            model_edge(eg);
            @(posedge clock);
            #1;
            chk_outs($sformatf("v%0d", i));
        end

        // Reset mid-operation: request pending, pointer away from 0 in round-robin mode
        @(negedge clock);
        flush_i = 1'b0;
        req_i   = 4'b1010;
        #1;
`ifdef CDB_FIXED_PRIO_EN
        chk("pre_rst_gnt", 64'(gnt_o), 64'(4'b0010));
`else
        chk("pre_rst_gnt", 64'(gnt_o), 64'(4'b1000));
`endif
        #2;
        reset = 1'b0;
        #1;
        exp_valid = 1'b0; exp_tag = '0; exp_data = '0; exp_src = 2'd0;
        chk("mid_rst_gnt", 64'(gnt_o), 64'(4'b0000));
        chk_outs("mid_rst");
        @(posedge clock);
        #1;
        chk_outs("mid_rst_edge");

        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("post_rst_gnt", 64'(gnt_o), 64'(4'b0010));
        model_edge(4'b0010);
        @(posedge clock);
        #1;
        chk_outs("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 5, meaning reorder-buffer tag width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning result data width.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port req_i, input, 4, meaning per-unit broadcast request (0 int, 1 mult, 2 div, 3 ld/st).
REQ-006 SHALL have port req_tag_i, input, 4*TAG_W, meaning the tag for unit n in bits [n*TAG_W +: TAG_W].
REQ-007 SHALL have port req_data_i, input, 4*DATA_W, meaning the result for unit n in bits [n*DATA_W +: DATA_W].
REQ-008 SHALL have port gnt_o, output, 4, meaning the combinational one-hot grant.
REQ-009 SHALL have port flush_i, input, 1, meaning the mispredict/exception flush.
REQ-010 SHALL have port cdb_valid_o, output, 1, meaning the registered CDB broadcast valid (drives RB_valid_rst).
REQ-011 SHALL have port cdb_tag_o, output, TAG_W, meaning the registered broadcast tag (drives RB_tag_rst).
REQ-012 SHALL have port cdb_data_o, output, DATA_W, meaning the registered broadcast data.
REQ-013 SHALL have port cdb_src_o, output, 2, meaning the index of the unit that owns the current broadcast.

Function
REQ-014 SHALL assert at most one gnt_o bit per cycle, only for a unit whose req_i bit is high.
REQ-015 SHALL define a transfer as req_i[n] & gnt_o[n] in one cycle.
REQ-016 SHALL require each requester to hold req_i, tag and data stable until granted; a request dropped before grant is simply not served.
REQ-017 SHALL have latency 1: on the edge after a transfer, cdb_valid_o=1, cdb_tag_o, cdb_data_o = granted unit's tag/data, cdb_src_o=n.
REQ-018 SHALL drive cdb_valid_o=0 on the edge after any cycle without a transfer; cdb_tag_o, cdb_data_o and cdb_src_o hold their previous values.
REQ-019 SHALL keep a 2-bit round-robin pointer ptr; priority order is ptr, ptr+1, ptr+2, ptr+3, all modulo 4.
REQ-020 SHALL update ptr to (g+1) mod 4 after a transfer from unit g (3 wraps to 0), and leave ptr unchanged when there is no transfer.
REQ-021 SHALL guarantee any continuously held request is granted within 4 cycles.
REQ-022 SHALL, when flush_i=1, force gnt_o=0 in that cycle, clear cdb_valid_o on the next edge and reset ptr to 0; flush has priority over all requests.
REQ-023 SHALL, when req_i=4'b0000, drive gnt_o=0 and take no state action.

Reset
REQ-024 SHALL, while reset=0, asynchronously clear cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_src_o and ptr to 0.
REQ-025 SHALL drive gnt_o=0 while reset=0.
REQ-026 SHALL discard any in-flight transfer when reset is asserted mid-operation; the first grant after release follows ptr=0 order.

Configuration
REQ-027 SHALL, with CDB_FIXED_PRIO_EN defined, use fixed priority 0>1>2>3 and hold ptr at 0.
REQ-028 SHALL, without CDB_FIXED_PRIO_EN, use the round-robin scheme of REQ-019..REQ-021.

Verification
REQ-029 SHALL verify reset: reset=0 with req_i=4'b1111 -> gnt_o=0, cdb_valid_o=0, all outputs 0.
REQ-030 SHALL verify the single request: req_i=4'b0100, tag 5'd9, data 32'hDEADBEEF -> gnt_o=4'b0100; next cycle cdb_valid_o=1, cdb_tag_o=9, cdb_data_o=DEADBEEF, cdb_src_o=2.
REQ-031 SHALL verify round-robin: req_i=4'b1111 held 5 cycles from reset -> grants 0,1,2,3,0 on successive cycles; cdb_valid_o=1 on each following cycle.
REQ-032 SHALL verify wrap: grant to unit 3, then req_i=4'b1001 -> unit 0 is granted next.
REQ-033 SHALL verify flush: flush_i=1 with req_i=4'b0010 -> gnt_o=0; next cycle cdb_valid_o=0 and ptr=0; with req_i=4'b0011 the following cycle -> unit 0 granted.
REQ-034 SHALL verify the fixed-priority build (CDB_FIXED_PRIO_EN): req_i=4'b1010 held 3 cycles -> unit 1 granted every cycle, unit 3 never.
